// File: rtl/io_pkg.sv
// io_pkg: register offsets, bit indices and interrupt FSM encoding shared by
// io_timer_intr and intr_handshake (and future I/O blocks on the same bus).
// No ports; import with "import io_pkg::*;".
package io_pkg;

  // Register map, decoded from io_addr[3:2]
  localparam logic [1:0] CTRL_OFS  = 2'd0;
  localparam logic [1:0] LOAD_OFS  = 2'd1;
  localparam logic [1:0] COUNT_OFS = 2'd2;
  localparam logic [1:0] STAT_OFS  = 2'd3;

  // CTRL bit indices
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  // STATUS bit indices
  localparam int STAT_PEND = 0;
  localparam int STAT_OVR  = 1;

  // Interrupt handshake FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ACKW = 2'd2;

endpackage

// File: rtl/intr_handshake.sv
// intr_handshake: 3-state INTR / INT_ACK request-acknowledge FSM.
// Ports: sys_clk, reset (async, active high), pend and ie (request sources),
//        INT_ACK (acknowledge from CPU), INTR (request to CPU, Moore output).
module intr_handshake
  import io_pkg::*;
(
  input  logic sys_clk,
  input  logic reset,
  input  logic pend,
  input  logic ie,
  input  logic INT_ACK,
  output logic INTR
);
  // Purpose: raise INTR once per pending event and hold it until acknowledged.
  // Latency: INTR registered; follows pend&ie at the next edge.
  // Backpressure: INTR held until INT_ACK; a new request waits for INT_ACK low.

  logic [1:0] state;
  logic [1:0] state_d;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (pend && ie) state_d = REQ;
      // Acknowledge wins; otherwise withdrawing IE cancels the request.
      REQ:  if (INT_ACK) state_d = ACKW;
            else if (!ie) state_d = IDLE;
      ACKW: if (!INT_ACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  assign INTR = (state == REQ);

endmodule

// File: rtl/io_timer_intr.sv
// io_timer_intr: memory-mapped down-counting interval timer with interrupt.
// Ports: sys_clk, reset (async, active high); CPU bus io_cs/io_rd/io_wr/
//        io_addr/io_din/io_dout (registered read data); INTR/INT_ACK handshake.
// Optional macro TIMER_PRESCALE_EN: tick every PRESCALE_DIV cycles instead of
// every cycle.
module io_timer_intr
  import io_pkg::*;
#(
  parameter int          PRESCALE_DIV = 4,
  parameter logic [31:0] RELOAD_RST   = 32'h0000_FFFF
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        io_cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_din,
  output logic [31:0] io_dout,
  output logic        INTR,
  input  logic        INT_ACK
);
  // Purpose: CTRL/LOAD/COUNT/STATUS register block driving a countdown timer.
  // Latency: writes take effect at the next edge; reads return data 1 cycle later.
  // Backpressure: none; every bus access is accepted in the cycle it is presented.

  logic [2:0]  ctrl,    ctrl_d;
  logic [31:0] load_r,  load_d;
  logic [31:0] count_r, count_d;
  logic [1:0]  status,  stat_d;
  logic [31:0] dout_d;
  logic        tick;
  logic        expire;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  sel;

  assign sel   = io_addr[3:2];
  assign wr_en = io_cs & io_wr;
  assign rd_en = io_cs & io_rd & ~io_wr;   // rd+wr together is a write only

`ifdef TIMER_PRESCALE_EN
  localparam int PS_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  logic [PS_W-1:0] ps_cnt;
  logic            ps_wrap;

  assign ps_wrap = (ps_cnt == PS_W'(PRESCALE_DIV - 1));

  // Held at zero while stopped so the first tick is a full period after enable.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)                 ps_cnt <= '0;
    else if (!ctrl[CTRL_EN])   ps_cnt <= '0;
    else if (ps_wrap)          ps_cnt <= '0;
    else                       ps_cnt <= ps_cnt + PS_W'(1);
  end

  assign tick = ctrl[CTRL_EN] & ps_wrap;
`else
  logic unused_div;
  assign unused_div = (PRESCALE_DIV == 0);
  assign tick = ctrl[CTRL_EN];
`endif

  logic unused_addr;
  assign unused_addr = ^{io_addr[31:4], io_addr[1:0]};

  // COUNT==0 also expires so LOAD=0 cannot underflow.
  assign expire = tick & (count_r <= 32'd1);

  always_comb begin
    ctrl_d  = ctrl;
    load_d  = load_r;
    count_d = count_r;
    stat_d  = status;

    if (tick) begin
      if (expire) begin
        if (ctrl[CTRL_AUTO]) begin
          count_d = load_r;            // old LOAD even if LOAD is written now
        end else begin
          count_d         = '0;
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end else begin
        count_d = count_r - 32'd1;
      end
    end

    // Software writes come after the hardware updates so a CTRL write
    // overrides the hardware EN clear.
    if (wr_en) begin
      case (sel)
        CTRL_OFS: begin
          ctrl_d = io_din[2:0];
          if (io_din[CTRL_EN] && !ctrl[CTRL_EN]) count_d = load_r;
        end
        LOAD_OFS: load_d = io_din;
        STAT_OFS: stat_d = status & ~io_din[1:0];
        default: ;                      // COUNT is read-only
      endcase
    end

    // Hardware set of PEND/OVR beats a same-cycle write-1-to-clear.
    if (expire) begin
      stat_d[STAT_PEND] = 1'b1;
      if (status[STAT_PEND]) stat_d[STAT_OVR] = 1'b1;
    end
  end

  always_comb begin
    dout_d = io_dout;
    if (rd_en) begin
      case (sel)
        CTRL_OFS:  dout_d = {29'd0, ctrl};
        LOAD_OFS:  dout_d = load_r;
        COUNT_OFS: dout_d = count_r;
        default:   dout_d = {30'd0, status};
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ctrl    <= '0;
      load_r  <= RELOAD_RST;
      count_r <= '0;
      status  <= '0;
      io_dout <= '0;
    end else begin
      ctrl    <= ctrl_d;
      load_r  <= load_d;
      count_r <= count_d;
      status  <= stat_d;
      io_dout <= dout_d;
    end
  end

  // The FSM sees next-cycle PEND/IE so INTR rises on the same edge PEND sets
  // and falls on the same edge IE is cleared.
  intr_handshake u_intr (
    .sys_clk (sys_clk),
    .reset   (reset),
    .pend    (stat_d[STAT_PEND]),
    .ie      (ctrl_d[CTRL_IE]),
    .INT_ACK (INT_ACK),
    .INTR    (INTR)
  );

endmodule

// File: tb/tb_io_timer_intr.sv
// tb_io_timer_intr: directed bench for io_timer_intr. Stimulus pushes expected
// values into queues; a negedge monitor pops and compares them.
module tb_io_timer_intr;

`ifdef TIMER_PRESCALE_EN
  localparam int TK = 4;
`else
  localparam int TK = 1;
`endif

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_LOAD  = 2'd1;
  localparam logic [1:0] A_COUNT = 2'd2;
  localparam logic [1:0] A_STAT  = 2'd3;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        io_cs, io_rd, io_wr;
  logic [31:0] io_addr, io_din, io_dout;
  logic        INTR, INT_ACK;

  io_timer_intr #(.PRESCALE_DIV(4), .RELOAD_RST(32'h0000_FFFF)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .io_cs   (io_cs),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .io_din  (io_din),
    .io_dout (io_dout),
    .INTR    (INTR),
    .INT_ACK (INT_ACK)
  );

  initial forever #5 sys_clk = ~sys_clk;

  // "now" checks: kind 0 = INTR, kind 1 = io_dout, compared at the next negedge
  int          nk_q[$];
  logic [31:0] nv_q[$];
  string       nt_q[$];
  // read-result checks, compared when a read's data appears
  logic [31:0] rv_q[$];
  string       rt_q[$];

  int          vectors = 0;
  int          miscompares = 0;
  logic        rd_vld = 1'b0;
  logic        done = 1'b0;
  int          k;
  logic [31:0] e, act;
  string       t;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [1:0] a);
    return {28'h1234_567, a, 2'b01};   // junk in undecoded bits
  endfunction

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b0;
    io_addr = addr_of(a); io_din = d;
    cyc(1);
    io_cs = 1'b0; io_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    rv_q.push_back(exp);
    rt_q.push_back(tag);
    io_cs = 1'b1; io_rd = 1'b1; io_wr = 1'b0;
    io_addr = addr_of(a);
    cyc(1);
    io_cs = 1'b0; io_rd = 1'b0;
  endtask

  task automatic now_chk(input int kind, input logic [31:0] exp, input string tag);
    nk_q.push_back(kind);
    nv_q.push_back(exp);
    nt_q.push_back(tag);
  endtask

  // Monitor
  always @(posedge sys_clk) rd_vld <= io_cs & io_rd & ~io_wr;

  always @(negedge sys_clk) begin
    while (nk_q.size() > 0) begin
      k = nk_q.pop_front();
      e = nv_q.pop_front();
      t = nt_q.pop_front();
      act = (k == 0) ? {31'd0, INTR} : io_dout;
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got %h, want %h", t, act, e);
      end
    end
    if (rd_vld) begin
      vectors++;
      if (rv_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: got %h, want no read data", io_dout);
      end else begin
        e = rv_q.pop_front();
        t = rt_q.pop_front();
        if (io_dout !== e) begin
          miscompares++;
          $display("FAIL %s: got %h, want %h", t, io_dout, e);
        end
      end
    end
    if (done) begin
      vectors++;
      if (nk_q.size() + rv_q.size() != 0) begin
        miscompares++;
        $display("FAIL leftover: got %0d pending, want 0", nk_q.size() + rv_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
    io_addr = '0; io_din = '0; INT_ACK = 1'b0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;

    // Reset values
    now_chk(0, 32'd0, "rst_intr");
    now_chk(1, 32'd0, "rst_dout");
    bus_rd(A_LOAD,  32'h0000_FFFF, "rst_load");
    bus_rd(A_CTRL,  32'd0, "rst_ctrl");
    bus_rd(A_COUNT, 32'd0, "rst_count");
    bus_rd(A_STAT,  32'd0, "rst_status");

    // One-shot: LOAD=5, EN+IE; INTR rises exactly 5 ticks after the CTRL edge
    bus_wr(A_LOAD, 32'd5);
    bus_wr(A_CTRL, 32'h5);
    for (int i = 0; i < 5 * TK; i++) begin
      now_chk(0, 32'd0, "oneshot_intr_early");
      cyc(1);
    end
    now_chk(0, 32'd1, "oneshot_intr_edge");
    bus_rd(A_STAT,  32'd1, "oneshot_pend");
    bus_rd(A_COUNT, 32'd0, "oneshot_count0");
    bus_rd(A_CTRL,  32'd4, "oneshot_en_clr");

    // COUNT is read-only
    bus_wr(A_COUNT, 32'hDEAD_BEEF);
    bus_rd(A_COUNT, 32'd0, "count_ro");

    // Handshake: INT_ACK held 3 cycles
    INT_ACK = 1'b1;
    now_chk(0, 32'd1, "ack_intr_before");
    cyc(1);
    now_chk(0, 32'd0, "ack_intr_drop");
    cyc(1);
    now_chk(0, 32'd0, "ack_intr_low1");
    cyc(1);
    now_chk(0, 32'd0, "ack_intr_low2");
    INT_ACK = 1'b0;
    bus_wr(A_STAT, 32'd1);
    now_chk(0, 32'd0, "no_reintr1");
    cyc(1);
    now_chk(0, 32'd0, "no_reintr2");
    bus_rd(A_STAT, 32'd0, "pend_cleared");

    // Auto-reload with PEND never cleared: COUNT 2,1,2,1 and OVR on 2nd expiry
    bus_wr(A_LOAD, 32'd2);
    bus_wr(A_CTRL, 32'h7);
    for (int i = 0; i < 4 * TK; i++)
      bus_rd(A_COUNT, (((i / TK) % 2) == 0) ? 32'd2 : 32'd1, "auto_count");
    bus_rd(A_STAT, 32'd3, "auto_ovr");
    now_chk(0, 32'd1, "auto_intr");
    // Clearing IE while requesting withdraws INTR
    bus_wr(A_CTRL, 32'h3);
    now_chk(0, 32'd0, "ie_clr_drop");
    bus_wr(A_CTRL, 32'h0);
    bus_wr(A_STAT, 32'h3);
    bus_rd(A_STAT, 32'd0, "stat_w1c");

    // Simultaneous rd+wr to LOAD: write only, io_dout holds
    bus_rd(A_LOAD, 32'd2, "load_before");
    io_cs = 1'b1; io_rd = 1'b1; io_wr = 1'b1;
    io_addr = addr_of(A_LOAD); io_din = 32'h1234_5678;
    cyc(1);
    io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
    now_chk(1, 32'd2, "rdwr_dout_hold");
    bus_rd(A_LOAD, 32'h1234_5678, "rdwr_load");

    // LOAD=3 one-shot: PEND after 3 ticks (3 or 12 cycles)
    bus_wr(A_LOAD, 32'd3);
    bus_wr(A_CTRL, 32'h5);
    cyc(3 * TK - 1);
    now_chk(0, 32'd0, "pre_intr_early");
    cyc(1);
    now_chk(0, 32'd1, "pre_intr_edge");
    bus_rd(A_STAT, 32'd1, "pre_pend");
    INT_ACK = 1'b1;
    cyc(1);
    now_chk(0, 32'd0, "pre_ack");
    INT_ACK = 1'b0;
    bus_wr(A_STAT, 32'd1);
    bus_wr(A_CTRL, 32'd0);

    // INT_ACK in IDLE is ignored
    INT_ACK = 1'b1;
    cyc(2);
    INT_ACK = 1'b0;
    now_chk(0, 32'd0, "idle_ack_ignored");

    // Reset mid-count
    bus_wr(A_LOAD, 32'd100);
    bus_wr(A_CTRL, 32'h5);
    cyc(3);
    reset = 1'b1;
    now_chk(0, 32'd0, "midrst_intr");
    now_chk(1, 32'd0, "midrst_dout");
    cyc(2);
    reset = 1'b0;
    bus_rd(A_LOAD,  32'h0000_FFFF, "midrst_load");
    bus_rd(A_COUNT, 32'd0, "midrst_count");
    bus_rd(A_CTRL,  32'd0, "midrst_ctrl");

    cyc(2);
    done = 1'b1;
  end

endmodule
